// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and default-latency definitions for the ALU issue controller.
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;
    localparam logic [1:0] ALU_OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_WAIT = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_t;

    localparam int ALU_LAT_ADD = 1;
    localparam int ALU_LAT_SUB = 1;
    localparam int ALU_LAT_MUL = 2;
    localparam int ALU_LAT_DIV = 4;

    function automatic int lat_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Loadable down-counter with a zero flag; counts the ALU settle cycles.
module alu_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one op at a time to the combinational ALU, waits its settle latency, returns the result.
// Optional macro ALU_DIVZERO_CHECK_EN: force 8'hFF and raise resp_err on divide-by-zero.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int LAT_ADD = ALU_LAT_ADD,
    parameter int LAT_SUB = ALU_LAT_SUB,
    parameter int LAT_MUL = ALU_LAT_MUL,
    parameter int LAT_DIV = ALU_LAT_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_rs,
    input  logic [7:0]       req_rt,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_rs,
    output logic [7:0]       alu_rt,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int LAT_MAX = lat_max4(LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV);
    localparam int CNT_W   = $clog2(LAT_MAX) + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the sender holds valid and payload stable until that edge.

    alu_state_t       state, state_next;
    logic             accept, capture;
    logic             cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic [TAG_W-1:0] tag_hold;
    int               lat_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ALU_ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ALU_ST_IDLE: if (req_valid)  state_next = ALU_ST_WAIT;
            ALU_ST_WAIT: if (cnt_zero)   state_next = ALU_ST_DONE;
            ALU_ST_DONE: if (resp_ready) state_next = ALU_ST_IDLE;
            default:                     state_next = ALU_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ALU_ST_IDLE);
        busy       = (state != ALU_ST_IDLE);
        resp_valid = (state == ALU_ST_DONE);
        accept     = (state == ALU_ST_IDLE) && req_valid;
        capture    = (state == ALU_ST_WAIT) && cnt_zero;
        cnt_dec    = (state == ALU_ST_WAIT) && !cnt_zero;
    end

    assign dbg_state = state;

    // The counter is loaded with LAT-1 so that the capture edge is exactly LAT edges after accept.
    always_comb begin
        case (req_op)
            ALU_OP_ADD: lat_sel = LAT_ADD;
            ALU_OP_SUB: lat_sel = LAT_SUB;
            ALU_OP_MUL: lat_sel = LAT_MUL;
            default:    lat_sel = LAT_DIV;
        endcase
        cnt_load_val = CNT_W'(lat_sel - 1);
    end

    alu_wait_counter #(.W(CNT_W)) u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_rs   <= '0;
            alu_rt   <= '0;
            alu_op   <= '0;
            tag_hold <= '0;
            resp_tag <= '0;
        end else begin
            if (accept) begin
                alu_rs   <= req_rs;
                alu_rt   <= req_rt;
                alu_op   <= req_op;
                tag_hold <= req_tag;
            end
            if (capture) resp_tag <= tag_hold;
        end
    end

`ifdef ALU_DIVZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (capture) begin
            if ((alu_op == ALU_OP_DIV) && (alu_rt == 8'h00)) begin
                resp_data <= 8'hFF;
                resp_err  <= 1'b1;
            end else begin
                resp_data <= alu_out;
                resp_err  <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     resp_data <= '0;
        else if (capture) resp_data <= alu_out;
    end

    assign resp_err = 1'b0;
`endif

endmodule
